// File: rtl/simplez_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simplez_pkg
// Description : Shared constants and types for the Simplez screen peripheral:
//               bus widths, memory-mapped register addresses and the serial
//               transmitter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package simplez_pkg;

    // CPU bus geometry
    localparam int DATAW    = 12;
    localparam int ADDRW    = 9;

    // Memory-mapped register addresses (keyboard pair reserved for the sibling block)
    localparam int SCR_STAT = 508;
    localparam int SCR_DATA = 509;
    localparam int KBD_STAT = 510;
    localparam int KBD_DATA = 511;

    // Serial transmitter states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/simplez_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : simplez_uart_tx
// Description : 8N1 serial transmitter, LSB first, idle high. A character is
//               taken when start is high in IDLE, or at the end of STOP for
//               back-to-back frames; load pulses on the edge it is taken.
//               Registers update on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module simplez_uart_tx #(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       load,
    output logic       tx
);
    import simplez_pkg::*;

    localparam int            CW     = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);

    tx_state_t     r_state;
    tx_state_t     w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_expire;

    assign w_expire = (r_cnt == C_LAST);
    assign busy     = (r_state != ST_IDLE);

    // Next-state decode, character-take strobe and line level
    always_comb begin
        w_next = r_state;
        load   = 1'b0;
        tx     = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_START;
                    load   = 1'b1;
                end
            end
            ST_START: begin
                tx = 1'b0;
                if (w_expire) w_next = ST_DATA;
            end
            ST_DATA: begin
                tx = r_shift[0];
                if (w_expire && (r_bit == 3'd7)) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_expire) begin
                    if (start) begin
                        w_next = ST_START;
                        load   = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State, baud counter (zeroed on every state entry), bit counter and shifter
    always_ff @(negedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
        end else begin
            r_state <= w_next;

            if ((w_next != r_state) || w_expire || (r_state == ST_IDLE))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if ((r_state == ST_DATA) && w_expire)
                r_bit <= r_bit + 3'd1;
            else if (r_state != ST_DATA)
                r_bit <= 3'd0;

            if (load)
                r_shift <= data;
            else if ((r_state == ST_DATA) && w_expire)
                r_shift <= {1'b0, r_shift[7:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/simplez_screen.sv
`default_nettype none
// ============================================================================
// Module      : simplez_screen
// Description : Simplez memory-mapped screen port. SCR_STAT (508) reads back
//               the ready flag, SCR_DATA (509) accepts a character which is
//               sent on tx as an 8N1 frame. Registers update on the falling
//               clock edge; reset is synchronous, active low.
//               Build option SIMPLEZ_SCREEN_FIFO_EN: queue characters in a
//               4-entry FIFO instead of a single holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module simplez_screen #(
    parameter int DATAW    = simplez_pkg::DATAW,
    parameter int ADDRW    = simplez_pkg::ADDRW,
    parameter int BAUD_DIV = 104
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [ADDRW-1:0] addr,
    input  logic             rd,
    input  logic             wr,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             hit,
    output logic             tx
);
    import simplez_pkg::*;

    logic       w_is_stat;
    logic       w_is_data;
    logic       w_wr_data;
    logic       w_ready;
    logic       w_start;
    logic       w_load;
    logic       w_busy;
    logic [7:0] w_tx_data;
    logic       w_unused_bits;

    assign w_is_stat     = (addr == ADDRW'(SCR_STAT));
    assign w_is_data     = (addr == ADDRW'(SCR_DATA));
    assign hit           = w_is_stat || w_is_data;
    assign w_wr_data     = wr && w_is_data;
    assign w_unused_bits = ^data_in[DATAW-1:8];

    // Read register: status returns ready sampled before any same-cycle write
    always_ff @(negedge clk) begin
        if (!rstn)
            data_out <= '0;
        else if (rd)
            data_out <= w_is_stat ? DATAW'(w_ready) : '0;
    end

`ifdef SIMPLEZ_SCREEN_FIFO_EN
    logic [7:0] r_mem [4];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;
    logic       w_full;
    logic       w_push;
    logic       w_unused_busy;

    assign w_full        = (r_count == 3'd4);
    assign w_ready       = !w_full;
    assign w_start       = (r_count != 3'd0);
    assign w_tx_data     = r_mem[r_rd_ptr];
    // A pop frees a slot in the same edge, so a write while full still lands
    assign w_push        = w_wr_data && (!w_full || w_load);
    assign w_unused_busy = w_busy;

    // FIFO storage
    always_ff @(negedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(negedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_load) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic       r_pending;
    logic [7:0] r_hold;

    // Only accept a character when the line is idle and nothing is waiting
    assign w_ready   = !w_busy && !r_pending;
    assign w_start   = r_pending;
    assign w_tx_data = r_hold;

    // Single holding register; cleared once the transmitter takes it
    always_ff @(negedge clk) begin
        if (!rstn) begin
            r_pending <= 1'b0;
            r_hold    <= 8'd0;
        end else if (w_wr_data && w_ready) begin
            r_pending <= 1'b1;
            r_hold    <= data_in[7:0];
        end else if (w_load) begin
            r_pending <= 1'b0;
        end
    end
`endif

    simplez_uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk   (clk),
        .rstn  (rstn),
        .start (w_start),
        .data  (w_tx_data),
        .busy  (w_busy),
        .load  (w_load),
        .tx    (tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_simplez_screen.sv
`default_nettype none
// ============================================================================
// Module      : tb_simplez_screen
// Description : Self-checking bench for simplez_screen with BAUD_DIV=4.
//               Register/decode vectors from a table, then hand-written
//               frame, busy-write, FIFO-full and mid-frame reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simplez_screen;

    localparam int BAUD = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [8:0]  addr = 9'd0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [11:0] data_in = 12'd0;
    logic [11:0] data_out;
    logic        hit;
    logic        tx;

    int total = 0;
    int bad   = 0;

    bit exp_q[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [8:0]  addr;
        logic [11:0] din;
        logic        exp_hit;
        logic [11:0] exp_dout;
    } vec_t;

    vec_t vt[13];

    always #5 clk = ~clk;

    simplez_screen #(
        .DATAW    (12),
        .ADDRW    (9),
        .BAUD_DIV (BAUD)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .data_in  (data_in),
        .data_out (data_out),
        .hit      (hit),
        .tx       (tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One active (falling) edge, then settle to the following rising edge
    task automatic step();
        @(negedge clk);
        @(posedge clk);
    endtask

    function automatic void push_ones(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endfunction

    function automatic void push_frame(input logic [7:0] ch);
        for (int b = 0; b < 10; b++) begin
            bit v;
            if (b == 0)      v = 1'b0;
            else if (b == 9) v = 1'b1;
            else             v = ch[b-1];
            for (int k = 0; k < BAUD; k++) exp_q.push_back(v);
        end
    endfunction

    task automatic run(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check(name, {31'd0, tx}, {31'd0, exp_q.pop_front()});
        end
    endtask

    task automatic do_write(input logic [7:0] ch, input logic rd_too, input string name);
        addr    = 9'd509;
        wr      = 1'b1;
        rd      = rd_too;
        data_in = {4'hA, ch};
        step();
        check({name, "_tx"}, {31'd0, tx}, {31'd0, exp_q.pop_front()});
        if (rd_too) check({name, "_rd509"}, {20'd0, data_out}, 32'd0);
        wr      = 1'b0;
        rd      = 1'b0;
        data_in = 12'd0;
    endtask

    task automatic read_stat(input string name, input logic [11:0] exp);
        addr = 9'd508;
        rd   = 1'b1;
        step();
        check(name, {20'd0, data_out}, {20'd0, exp});
        rd   = 1'b0;
    endtask

    initial begin
        // Register/decode vectors: {rd, wr, addr, din, hit, data_out}
        vt[0]  = '{1'b1, 1'b0, 9'd508, 12'h000, 1'b1, 12'h001};
        vt[1]  = '{1'b1, 1'b0, 9'd507, 12'h000, 1'b0, 12'h000};
        vt[2]  = '{1'b1, 1'b0, 9'd508, 12'h000, 1'b1, 12'h001};
        vt[3]  = '{1'b1, 1'b0, 9'd510, 12'h000, 1'b0, 12'h000};
        vt[4]  = '{1'b1, 1'b0, 9'd508, 12'h000, 1'b1, 12'h001};
        vt[5]  = '{1'b0, 1'b0, 9'd000, 12'h000, 1'b0, 12'h001};
        vt[6]  = '{1'b1, 1'b0, 9'd509, 12'h000, 1'b1, 12'h000};
        vt[7]  = '{1'b0, 1'b0, 9'd508, 12'h000, 1'b1, 12'h000};
        vt[8]  = '{1'b0, 1'b1, 9'd507, 12'h041, 1'b0, 12'h000};
        vt[9]  = '{1'b0, 1'b1, 9'd510, 12'h041, 1'b0, 12'h000};
        vt[10] = '{1'b0, 1'b1, 9'd508, 12'h041, 1'b1, 12'h000};
        vt[11] = '{1'b1, 1'b0, 9'd511, 12'h000, 1'b0, 12'h000};
        vt[12] = '{1'b1, 1'b0, 9'd508, 12'h000, 1'b1, 12'h001};

        // Reset held for three edges
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_tx", {31'd0, tx}, 32'd1);
            check("rst_dout", {20'd0, data_out}, 32'd0);
        end
        rstn = 1'b1;
        read_stat("rst_stat", 12'h001);

        // Decode and read-register vectors
        foreach (vt[i]) begin
            rd      = vt[i].rd;
            wr      = vt[i].wr;
            addr    = vt[i].addr;
            data_in = vt[i].din;
            #1;
            check($sformatf("vec%0d_hit", i), {31'd0, hit}, {31'd0, vt[i].exp_hit});
            step();
            check($sformatf("vec%0d_dout", i), {20'd0, data_out}, {20'd0, vt[i].exp_dout});
            check($sformatf("vec%0d_tx", i), {31'd0, tx}, 32'd1);
        end
        rd = 1'b0;
        wr = 1'b0;
        exp_q.delete();
        push_ones(12);
        run("decode_idle", 12);

        // Single character with status polled during the frame
        exp_q.delete();
        push_ones(1);
        push_frame(8'h41);
        do_write(8'h41, 1'b1, "single");
        addr = 9'd508;
        rd   = 1'b1;
        for (int i = 0; i < 10 * BAUD; i++) begin
            step();
            check("single_tx", {31'd0, tx}, {31'd0, exp_q.pop_front()});
            check("single_busy_stat", {20'd0, data_out}, 32'd0);
        end
        step();
        check("single_stop_end", {31'd0, tx}, 32'd1);
        step();
        check("single_ready", {20'd0, data_out}, 32'd1);
        rd = 1'b0;

        // Write while busy
        exp_q.delete();
        push_ones(1);
        push_frame(8'h41);
`ifdef SIMPLEZ_SCREEN_FIFO_EN
        push_frame(8'h42);
        push_ones(1);
`else
        push_ones(41);
`endif
        do_write(8'h41, 1'b1, "busy1");
        run("busy_a", 4);
        do_write(8'h42, 1'b1, "busy2");
        run("busy_b", exp_q.size());
        read_stat("busy_ready", 12'h001);

        // Six consecutive writes: queue fills after the fifth
        exp_q.delete();
        push_ones(1);
        push_frame(8'h30);
`ifdef SIMPLEZ_SCREEN_FIFO_EN
        push_frame(8'h31);
        push_frame(8'h32);
        push_frame(8'h33);
        push_frame(8'h34);
`endif
        push_ones(10);
        for (int i = 0; i < 6; i++) do_write(8'h30 + 8'(i), 1'b0, "full_wr");
        addr = 9'd508;
        rd   = 1'b1;
        step();
        check("full_tx", {31'd0, tx}, {31'd0, exp_q.pop_front()});
        check("full_stat", {20'd0, data_out}, 32'd0);
        rd = 1'b0;
        run("full_frames", exp_q.size());
        read_stat("full_ready", 12'h001);

        // Reset in the middle of a frame
        exp_q.delete();
        push_ones(1);
        push_frame(8'h41);
        do_write(8'h41, 1'b0, "mid");
        check("mid_hold_dout", {20'd0, data_out}, 32'd1);
        run("mid_frame", 15);
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("mid_rst_tx", {31'd0, tx}, 32'd1);
            check("mid_rst_dout", {20'd0, data_out}, 32'd0);
        end
        rstn = 1'b1;
        exp_q.delete();
        push_ones(45);
        run("mid_no_frame", 45);
        read_stat("mid_ready", 12'h001);

        // Clean frame after the aborted one
        exp_q.delete();
        push_ones(1);
        push_frame(8'h55);
        push_ones(2);
        do_write(8'h55, 1'b0, "post");
        run("post_frame", exp_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
